// File: rtl/rj_load_ctrl_if.sv
// Bus between rj_load_ctrl and its environment: the serial load inputs, the
// sweep controls, and both ports of the 16x16 Rj coefficient memory.
//   master : the controller (drives the memory ports and status flags)
//   slave  : the environment (serial source, sweep requester, memory)
// Serial/control : Frame, serial_in, load_start, seq_start, seq_stall
// Memory write   : mem_write_en, mem_frame, Write_Address, mem_data
// Memory read    : read_enable, Read_Address, rd_valid, rd_last
// Status         : load_done, busy, frame_err, chk_err
interface rj_load_ctrl_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 4
);
    logic              Frame;
    logic              serial_in;
    logic              load_start;
    logic              seq_start;
    logic              seq_stall;
    logic              mem_write_en;
    logic              mem_frame;
    logic [ADDR_W-1:0] Write_Address;
    logic [DATA_W-1:0] mem_data;
    logic              read_enable;
    logic [ADDR_W-1:0] Read_Address;
    logic              rd_valid;
    logic              rd_last;
    logic              load_done;
    logic              busy;
    logic              frame_err;
    logic              chk_err;

    modport master (
        input  Frame, serial_in, load_start, seq_start, seq_stall,
        output mem_write_en, mem_frame, Write_Address, mem_data,
        output read_enable, Read_Address, rd_valid, rd_last,
        output load_done, busy, frame_err, chk_err
    );

    modport slave (
        output Frame, serial_in, load_start, seq_start, seq_stall,
        input  mem_write_en, mem_frame, Write_Address, mem_data,
        input  read_enable, Read_Address, rd_valid, rd_last,
        input  load_done, busy, frame_err, chk_err
    );
endinterface

// File: rtl/rj_load_ctrl.sv
// Rj coefficient memory controller. Loads NUM_WORDS words from an MSB-first
// serial stream (one Frame pulse per word) into consecutive memory addresses,
// then sequences read sweeps for the filter datapath. Load and sweep share the
// FSM, so the two memory ports are never active together.
// Ports:
//   Sclk    : clock, all logic on posedge
//   Reset_n : synchronous active-low reset
//   bus     : rj_load_ctrl_if.master (serial input, sweep control, memory
//             write/read ports, load_done/busy/frame_err/chk_err status)
// Optional feature: define RJ_SUM_CHECK_EN to expect a trailing checksum word
// (sum of the loaded words mod 2^DATA_W) after each load; a mismatch sets the
// sticky chk_err. Without it chk_err is tied low.
module rj_load_ctrl #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned ADDR_W    = 4,
    parameter int unsigned NUM_WORDS = 16
) (
    input  logic           Sclk,
    input  logic           Reset_n,
    rj_load_ctrl_if.master bus
);
    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam int unsigned BIT_W = $clog2(DATA_W + 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_FRAME,
        SHIFT,
        WRITE,
        SWEEP
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    word_cnt_q, word_cnt_d;
    logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [DATA_W-2:0]   shift_q, shift_d;
    logic [DATA_W-1:0]   mem_data_q, mem_data_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic                wr_en_q, wr_en_d;
    logic                rd_en_q, rd_en_d;
    logic                load_done_q, load_done_d;
    logic                busy_q, busy_d;
    logic                frame_err_q, frame_err_d;

    logic [DATA_W-1:0]   shift_nxt;
    logic                word_full;
    logic                last_data;
    logic                more_words;
    logic                is_csum;

    // The word completes from the held upper bits plus the bit on the wire,
    // so the shift register only needs DATA_W-1 bits.
    assign shift_nxt = {shift_q, bus.serial_in};
    assign word_full = (bit_cnt_q == BIT_W'(DATA_W - 1));
    assign last_data = (word_cnt_q == CNT_W'(NUM_WORDS - 1));

`ifdef RJ_SUM_CHECK_EN
    logic [DATA_W-1:0] sum_q, sum_d;
    logic              chk_err_q, chk_err_d;

    // After the last data word the load stays open for the checksum word.
    assign more_words = 1'b1;
    assign is_csum    = (word_cnt_q == CNT_W'(NUM_WORDS));

    // Running sum of data words; compared against the trailing checksum.
    always_comb begin
        sum_d     = sum_q;
        chk_err_d = chk_err_q;
        if (state_q == IDLE && bus.load_start) begin
            sum_d     = '0;
            chk_err_d = 1'b0;
        end else if (state_q == SHIFT && !bus.Frame && word_full) begin
            if (is_csum) begin
                chk_err_d = chk_err_q | (shift_nxt != sum_q);
            end else begin
                sum_d = sum_q + shift_nxt;
            end
        end
    end

    always_ff @(posedge Sclk) begin
        if (!Reset_n) begin
            sum_q     <= '0;
            chk_err_q <= 1'b0;
        end else begin
            sum_q     <= sum_d;
            chk_err_q <= chk_err_d;
        end
    end

    assign bus.chk_err = chk_err_q;
`else
    assign more_words  = ~last_data;
    assign is_csum     = 1'b0;
    assign bus.chk_err = 1'b0;
`endif

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        word_cnt_d  = word_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        mem_data_d  = mem_data_q;
        wr_addr_d   = wr_addr_q;
        rd_addr_d   = rd_addr_q;
        rd_en_d     = rd_en_q;
        frame_err_d = frame_err_q;
        wr_en_d     = 1'b0;
        load_done_d = 1'b0;

        case (state_q)
            IDLE: begin
                // load_start wins over a simultaneous seq_start
                if (bus.load_start) begin
                    state_d     = WAIT_FRAME;
                    word_cnt_d  = '0;
                    frame_err_d = 1'b0;
                end else if (bus.seq_start) begin
                    state_d   = SWEEP;
                    rd_en_d   = 1'b1;
                    rd_addr_d = '0;
                end
            end

            WAIT_FRAME: begin
                if (bus.Frame) begin
                    state_d   = SHIFT;
                    shift_d   = (DATA_W-1)'(bus.serial_in);
                    bit_cnt_d = BIT_W'(1);
                end
            end

            SHIFT: begin
                if (bus.Frame) begin
                    // Frame inside a word: drop the partial word, restart here
                    frame_err_d = 1'b1;
                    shift_d     = (DATA_W-1)'(bus.serial_in);
                    bit_cnt_d   = BIT_W'(1);
                end else begin
                    shift_d   = shift_nxt[DATA_W-2:0];
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    if (word_full) begin
                        if (is_csum) begin
                            load_done_d = 1'b1;
                            state_d     = IDLE;
                        end else begin
                            mem_data_d = shift_nxt;
                            wr_en_d    = 1'b1;
                            wr_addr_d  = word_cnt_q[ADDR_W-1:0];
                            state_d    = WRITE;
                        end
                    end
                end
            end

            WRITE: begin
                word_cnt_d = word_cnt_q + CNT_W'(1);
                if (more_words) begin
                    // A Frame in the write cycle is the next word's MSB
                    if (bus.Frame) begin
                        state_d   = SHIFT;
                        shift_d   = (DATA_W-1)'(bus.serial_in);
                        bit_cnt_d = BIT_W'(1);
                    end else begin
                        state_d = WAIT_FRAME;
                    end
                end else begin
                    load_done_d = 1'b1;
                    state_d     = IDLE;
                end
            end

            SWEEP: begin
                if (!bus.seq_stall) begin
                    if (rd_addr_q == ADDR_W'(NUM_WORDS - 1)) begin
                        state_d = IDLE;
                        rd_en_d = 1'b0;
                    end else begin
                        rd_addr_d = rd_addr_q + ADDR_W'(1);
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset leaves the memory itself untouched.
    always_ff @(posedge Sclk) begin
        if (!Reset_n) begin
            state_q     <= IDLE;
            word_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            mem_data_q  <= '0;
            wr_addr_q   <= '0;
            rd_addr_q   <= '0;
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            load_done_q <= 1'b0;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_cnt_q  <= word_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            mem_data_q  <= mem_data_d;
            wr_addr_q   <= wr_addr_d;
            rd_addr_q   <= rd_addr_d;
            wr_en_q     <= wr_en_d;
            rd_en_q     <= rd_en_d;
            load_done_q <= load_done_d;
            busy_q      <= busy_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign bus.mem_write_en  = wr_en_q;
    assign bus.mem_frame     = wr_en_q;
    assign bus.Write_Address = wr_addr_q;
    assign bus.mem_data      = mem_data_q;
    assign bus.read_enable   = rd_en_q;
    assign bus.Read_Address  = rd_addr_q;
    // Stall gates the current read combinationally
    assign bus.rd_valid      = rd_en_q & ~bus.seq_stall;
    assign bus.rd_last       = rd_en_q & ~bus.seq_stall & (rd_addr_q == ADDR_W'(NUM_WORDS - 1));
    assign bus.load_done     = load_done_q;
    assign bus.busy          = busy_q;
    assign bus.frame_err     = frame_err_q;
endmodule

// File: tb/tb_rj_load_ctrl.sv
// Testbench for rj_load_ctrl: randomized serial loads and read sweeps checked
// against a reference memory and expected event timing derived from the
// serial stream the bench itself generates.
module tb_rj_load_ctrl;
    localparam int unsigned DATA_W    = 16;
    localparam int unsigned ADDR_W    = 4;
    localparam int unsigned NUM_WORDS = 16;
    localparam int unsigned OUT_W     = 2 * ADDR_W + DATA_W + 9;
`ifdef RJ_SUM_CHECK_EN
    localparam bit SUM_EN = 1'b1;
`else
    localparam bit SUM_EN = 1'b0;
`endif

    logic Sclk    = 1'b0;
    logic Reset_n = 1'b0;
    int   cyc     = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    rj_load_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    rj_load_ctrl #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .NUM_WORDS(NUM_WORDS)
    ) dut (
        .Sclk   (Sclk),
        .Reset_n(Reset_n),
        .bus    (bus.master)
    );

    always #5 Sclk = ~Sclk;
    always @(posedge Sclk) cyc <= cyc + 1;

    logic [OUT_W-1:0] all_outs;
    assign all_outs = {bus.mem_write_en, bus.mem_frame, bus.Write_Address, bus.mem_data,
                       bus.read_enable, bus.Read_Address, bus.rd_valid, bus.rd_last,
                       bus.load_done, bus.busy, bus.frame_err, bus.chk_err};

    // Reference contents, and a model of the real memory fed by DUT writes
    logic [DATA_W-1:0] ref_mem [NUM_WORDS];
    logic [DATA_W-1:0] dut_mem [NUM_WORDS];
    int                act_wr_cyc  [$];
    int                act_wr_addr [$];
    logic [DATA_W-1:0] act_wr_data [$];
    int                act_ld_cyc  [$];
    bit                loading    = 1'b0;
    int                rd_in_load = 0;
    int                frame_mis  = 0;

    always @(negedge Sclk) begin
        if (Reset_n) begin
            if (bus.mem_write_en === 1'b1) begin
                act_wr_cyc.push_back(cyc);
                act_wr_addr.push_back(int'(bus.Write_Address));
                act_wr_data.push_back(bus.mem_data);
                dut_mem[bus.Write_Address] = bus.mem_data;
            end
            if (bus.mem_frame !== bus.mem_write_en) frame_mis++;
            if (bus.load_done === 1'b1) act_ld_cyc.push_back(cyc);
            if (loading && bus.read_enable !== 1'b0) rd_in_load++;
        end
    end

    task automatic tick();
        @(posedge Sclk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.Frame      = 1'b0;
        bus.serial_in  = 1'b0;
        bus.load_start = 1'b0;
        bus.seq_start  = 1'b0;
        bus.seq_stall  = 1'b0;
    endtask

    // Gap cycles, optional aborted prefix, then one framed MSB-first word
    task automatic send_word(input logic [DATA_W-1:0] w, input int gap, input int early_bits,
                             input bit noise, output int lsb_cyc);
        for (int g = 0; g < gap; g++) begin
            tick();
            bus.Frame      = 1'b0;
            bus.serial_in  = 1'($urandom);
            bus.load_start = noise ? 1'($urandom) : 1'b0;
            bus.seq_start  = noise ? 1'($urandom) : 1'b0;
        end
        for (int b = 0; b < early_bits; b++) begin
            tick();
            bus.Frame      = (b == 0);
            bus.serial_in  = 1'($urandom);
            bus.load_start = 1'b0;
            bus.seq_start  = 1'b0;
        end
        for (int b = DATA_W - 1; b >= 0; b--) begin
            tick();
            bus.Frame      = (b == DATA_W - 1);
            bus.serial_in  = w[b];
            bus.load_start = 1'b0;
            bus.seq_start  = 1'b0;
        end
        lsb_cyc = cyc;
    endtask

    // Full load; expected write cycle = LSB cycle + 1, load_done one after last write
    task automatic run_load(input int data_mode, input int gap_idx, input int gap_len,
                            input bit rnd_gaps, input int early_idx, input bit noise,
                            input bit with_seq, input int csum_delta);
        logic [DATA_W-1:0] w;
        logic [DATA_W-1:0] sum;
        int exp_cyc [$];
        int lsb;
        int gap;
        int exp_ld;
        bit exp_chk;
        sum = '0;
        lsb = 0;
        act_wr_cyc.delete();
        act_wr_addr.delete();
        act_wr_data.delete();
        act_ld_cyc.delete();
        rd_in_load = 0;
        loading    = 1'b1;
        tick();
        bus.load_start = 1'b1;
        bus.seq_start  = with_seq;
        bus.Frame      = 1'b0;
        for (int i = 0; i < int'(NUM_WORDS); i++) begin
            case (data_mode)
                0:       w = DATA_W'(i + 1);
                1:       w = DATA_W'($urandom);
                default: w = 16'h1000;
            endcase
            gap = (i == gap_idx) ? gap_len : (rnd_gaps ? int'($urandom_range(0, 3)) : 0);
            send_word(w, gap, (i == early_idx) ? 9 : 0, noise, lsb);
            exp_cyc.push_back(lsb + 1);
            ref_mem[i] = w;
            sum = sum + w;
        end
`ifdef RJ_SUM_CHECK_EN
        send_word(sum + DATA_W'(csum_delta), 0, 0, 1'b0, lsb);
        exp_ld = lsb + 1;
`else
        exp_ld = lsb + 2;
`endif
        exp_chk = SUM_EN && (DATA_W'(csum_delta) != '0);
        for (int k = 0; k < 4; k++) begin
            tick();
            idle_inputs();
        end
        @(negedge Sclk);
        loading = 1'b0;

        n_checks++;
        if (act_wr_cyc.size() != int'(NUM_WORDS)) begin
            n_fail++;
            $display("FAIL load write count: got %0d expected %0d", act_wr_cyc.size(), NUM_WORDS);
        end
        for (int i = 0; i < int'(NUM_WORDS) && i < act_wr_cyc.size(); i++) begin
            n_checks++;
            if (act_wr_cyc[i] != exp_cyc[i] || act_wr_addr[i] != i || act_wr_data[i] !== ref_mem[i]) begin
                n_fail++;
                $display("FAIL load write %0d: got cyc %0d addr %0d data %h expected cyc %0d addr %0d data %h",
                         i, act_wr_cyc[i], act_wr_addr[i], act_wr_data[i], exp_cyc[i], i, ref_mem[i]);
            end
        end
        n_checks++;
        if (act_ld_cyc.size() != 1 || act_ld_cyc[0] != exp_ld) begin
            n_fail++;
            $display("FAIL load_done: got %0d pulses first at %0d expected 1 pulse at %0d",
                     act_ld_cyc.size(), (act_ld_cyc.size() > 0) ? act_ld_cyc[0] : -1, exp_ld);
        end
        n_checks++;
        if (bus.frame_err !== (early_idx >= 0)) begin
            n_fail++;
            $display("FAIL frame_err after load: got %b expected %b", bus.frame_err, early_idx >= 0);
        end
        n_checks++;
        if (bus.chk_err !== exp_chk) begin
            n_fail++;
            $display("FAIL chk_err after load: got %b expected %b", bus.chk_err, exp_chk);
        end
        n_checks++;
        if (rd_in_load != 0) begin
            n_fail++;
            $display("FAIL read during load: got %0d read cycles expected 0", rd_in_load);
        end
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL busy after load: got %b expected 0", bus.busy);
        end
    endtask

    // mode 0: no stalls, 1: stall on sweep cycles 2 and 3, 2: random stalls
    task automatic run_sweep(input int mode);
        int addr;
        int stalls;
        int lasts;
        int k;
        bit st;
        bit done;
        logic [ADDR_W+3:0] got;
        logic [ADDR_W+3:0] exp;
        addr   = 0;
        stalls = 0;
        lasts  = 0;
        k      = 0;
        done   = 1'b0;
        tick();
        bus.seq_start = 1'b1;
        bus.seq_stall = 1'b0;
        while (!done && k < 40) begin
            k++;
            tick();
            bus.seq_start = 1'b0;
            st = (mode == 1) ? (k == 2 || k == 3) : (mode == 2) ? ($urandom_range(0, 3) == 0) : 1'b0;
            bus.seq_stall = st;
            @(negedge Sclk);
            got = {bus.read_enable, bus.Read_Address, bus.rd_valid, bus.rd_last, bus.busy};
            exp = {1'b1, ADDR_W'(addr), ~st, (~st) & (addr == int'(NUM_WORDS) - 1), 1'b1};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL sweep cycle %0d {ren,addr,valid,last,busy}: got %h expected %h", k, got, exp);
            end
            if (bus.rd_last === 1'b1) lasts++;
            if (st) begin
                stalls++;
            end else begin
                n_checks++;
                if (dut_mem[bus.Read_Address] !== ref_mem[addr]) begin
                    n_fail++;
                    $display("FAIL sweep data addr %0d: got %h expected %h",
                             addr, dut_mem[bus.Read_Address], ref_mem[addr]);
                end
                if (addr == int'(NUM_WORDS) - 1) done = 1'b1;
                addr++;
            end
        end
        n_checks++;
        if (!done || k != int'(NUM_WORDS) + stalls) begin
            n_fail++;
            $display("FAIL sweep length: got %0d cycles expected %0d", k, int'(NUM_WORDS) + stalls);
        end
        n_checks++;
        if (lasts != 1) begin
            n_fail++;
            $display("FAIL rd_last count: got %0d expected 1", lasts);
        end
        tick();
        bus.seq_stall = 1'b0;
        @(negedge Sclk);
        n_checks++;
        if ({bus.read_enable, bus.busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL sweep end {ren,busy}: got %b expected 00", {bus.read_enable, bus.busy});
        end
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        idle_inputs();
        repeat (3) @(posedge Sclk);
        @(negedge Sclk);
        n_checks++;
        if (all_outs !== '0) begin
            n_fail++;
            $display("FAIL reset outputs: got %h expected 0", all_outs);
        end
        tick();
        Reset_n = 1'b1;
        tick();
        @(negedge Sclk);
        n_checks++;
        if (all_outs !== '0) begin
            n_fail++;
            $display("FAIL idle after reset: got %h expected 0", all_outs);
        end
    endtask

    task automatic test_load_sweep();
        run_load(0, -1, 0, 1'b0, -1, 1'b0, 1'b0, 0);
        run_sweep(0);
    endtask

    task automatic test_gap();
        run_load(1, 3, 5, 1'b0, -1, 1'b1, 1'b0, 0);
        run_sweep(0);
    endtask

    task automatic test_early_frame();
        run_load(1, -1, 0, 1'b0, 2, 1'b0, 1'b0, 0);
        run_sweep(0);
        n_checks++;
        if (bus.frame_err !== 1'b1) begin
            n_fail++;
            $display("FAIL frame_err sticky: got %b expected 1", bus.frame_err);
        end
        run_load(1, -1, 0, 1'b1, -1, 1'b0, 1'b0, 0);
    endtask

    task automatic test_stalled_sweep();
        run_sweep(1);
    endtask

    task automatic test_arbitration();
        run_load(1, -1, 0, 1'b1, -1, 1'b0, 1'b1, 0);
        run_sweep(2);
    endtask

    task automatic test_random();
        for (int r = 0; r < 3; r++) begin
            run_load(1, -1, 0, 1'b1, -1, 1'b1, 1'b0, 0);
            run_sweep(2);
        end
    endtask

    task automatic test_reset_mid();
        int lsb;
        tick();
        bus.load_start = 1'b1;
        for (int i = 0; i < 7; i++) send_word(DATA_W'($urandom), 0, 0, 1'b0, lsb);
        for (int b = 0; b < 5; b++) begin
            tick();
            bus.Frame     = (b == 0);
            bus.serial_in = 1'($urandom);
        end
        @(negedge Sclk);
        n_checks++;
        if (bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL busy mid-load: got %b expected 1", bus.busy);
        end
        tick();
        Reset_n        = 1'b0;
        bus.Frame      = 1'b1;
        bus.serial_in  = 1'b1;
        bus.load_start = 1'b1;
        bus.seq_start  = 1'b1;
        tick();
        Reset_n = 1'b1;
        idle_inputs();
        @(negedge Sclk);
        n_checks++;
        if (all_outs !== '0) begin
            n_fail++;
            $display("FAIL reset mid-load outputs: got %h expected 0", all_outs);
        end
        tick();
        @(negedge Sclk);
        n_checks++;
        if (all_outs !== '0) begin
            n_fail++;
            $display("FAIL idle after mid-load reset: got %h expected 0", all_outs);
        end
        run_load(0, -1, 0, 1'b0, -1, 1'b0, 1'b0, 0);
        run_sweep(0);
    endtask

    task automatic test_checksum();
        run_load(2, -1, 0, 1'b0, -1, 1'b0, 1'b0, 0);
        run_load(2, -1, 0, 1'b1, -1, 1'b0, 1'b0, 1);
        run_sweep(0);
        run_load(1, -1, 0, 1'b1, -1, 1'b0, 1'b0, 0);
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_load_sweep();
        test_gap();
        test_early_frame();
        test_stalled_sweep();
        test_arbitration();
        test_random();
        test_reset_mid();
        test_checksum();
        n_checks++;
        if (frame_mis != 0) begin
            n_fail++;
            $display("FAIL mem_frame vs mem_write_en: got %0d differing cycles expected 0", frame_mis);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
